// File: rtl/prog_loader_mem_pkg.sv
// Shared types and sizes for the instruction memory and its boot loader.
package prog_loader_mem_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  localparam logic [6:0] LD_MAX_HDR = 7'd127;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    CHK  = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  // CPU virtual fetch address: bank select (mode) over 32-word ip
  typedef struct packed {
    logic [1:0] mode;
    logic [4:0] addr;
  } fetch_addr_t;

endpackage

// File: rtl/prog_mem.sv
// DEPTH x DATA_W flop storage: async clear, one sync write port, one comb read port.
module prog_mem
  import prog_loader_mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array; reset returns every word to zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read returns the pre-write value when write and read hit the same word
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader_mem.sv
// Instruction memory with a byte-stream boot loader that gates the CPU reset.
module prog_loader_mem
  import prog_loader_mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic              ld_start,
  input  logic              run_req,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              cpu_run,
  output logic              load_err
);

  loader_state_t state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              xfer;
  fetch_addr_t       fetch;

  // Byte-accepting states, blocked while a restart pulse is present
  assign ld_ready = ((state_q == HDR) || (state_q == LOAD) || (state_q == CHK)) && !ld_start;
  assign xfer     = ld_valid && ld_ready;
  assign cpu_run  = (state_q == RUN);
  assign load_err = err_q;
  assign fetch    = fetch_addr_t'(addr);

  // Loader state, pointers, running checksum and error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  // Next-state: ld_start from any state restarts the frame and beats run_req
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    if (ld_start) begin
      state_d = HDR;
      wptr_d  = '0;
      sum_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (run_req) state_d = RUN;
        HDR: begin
          if (xfer) begin
            if (ld_data[7]) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              cnt_d   = ld_data[6:0] & LD_MAX_HDR;
              wptr_d  = '0;
              sum_d   = '0;
              state_d = LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            mem_we = 1'b1;
            sum_d  = sum_q + ld_data;
            wptr_d = wptr_q + ADDR_W'(1);
            if (cnt_q == 7'd0) state_d = CHK;
            else               cnt_d   = cnt_q - 7'd1;
          end
        end
        CHK: begin
          if (xfer) begin
            if (ld_data == sum_q) begin
              state_d = RUN;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end
        end
        RUN: state_d = RUN;
        ERR: if (run_req) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  prog_mem u_mem (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (ld_data),
    .raddr ({fetch.mode, fetch.addr}),
    .rdata (data)
  );

endmodule

// File: tb/tb_prog_loader_mem.sv
// Bench for prog_loader_mem: directed vector tables, corner sequences and random traffic vs a frame-level model.
module tb_prog_loader_mem;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] addr;
  logic [7:0] data;
  logic       ld_start, run_req, ld_valid, ld_ready, cpu_run, load_err;
  logic [7:0] ld_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  prog_loader_mem dut (
    .clock(clock), .reset(reset), .addr(addr), .data(data),
    .ld_start(ld_start), .run_req(run_req), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .cpu_run(cpu_run), .load_err(load_err)
  );

  // Frame-level model: where we are in the frame, bytes still owed, image contents
  localparam int PH_IDLE = 0, PH_HDR = 1, PH_PAY = 2, PH_SUM = 3, PH_RUN = 4, PH_ERR = 5;
  int         m_phase;
  int         m_left;
  int         m_next;
  int         m_sum;
  bit         m_err;
  logic [7:0] m_mem [128];

  function automatic bit m_ready(input bit start);
    return (m_phase == PH_HDR || m_phase == PH_PAY || m_phase == PH_SUM) && !start;
  endfunction

  task automatic m_reset();
    m_phase = PH_IDLE; m_left = 0; m_next = 0; m_sum = 0; m_err = 0;
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
  endtask

  task automatic m_step(input bit start, input bit run, input bit valid, input logic [7:0] d);
    bit x;
    x = valid && m_ready(start);
    if (start) begin
      m_phase = PH_HDR; m_next = 0; m_sum = 0; m_err = 0;
    end else if (x && m_phase == PH_HDR) begin
      if (int'(d) > 127) begin m_phase = PH_ERR; m_err = 1; end
      else begin m_left = int'(d) + 1; m_next = 0; m_sum = 0; m_phase = PH_PAY; end
    end else if (x && m_phase == PH_PAY) begin
      m_mem[m_next] = d;
      m_next++;
      m_sum = (m_sum + int'(d)) % 256;
      m_left--;
      if (m_left == 0) m_phase = PH_SUM;
    end else if (x && m_phase == PH_SUM) begin
      if (int'(d) == m_sum) m_phase = PH_RUN;
      else begin m_phase = PH_ERR; m_err = 1; end
    end else if (run && (m_phase == PH_IDLE || m_phase == PH_ERR)) begin
      m_phase = PH_RUN;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input int k);
    addr = 7'(k);
    #1;
    check($sformatf("mem[%0d]", k), data, m_mem[k]);
  endtask

  // One clock: check comb ready/read before the edge, then registered outputs after it
  task automatic cycle(input bit start, input bit run, input bit valid, input logic [7:0] d,
                       input int raddr);
    ld_start = start; run_req = run; ld_valid = valid; ld_data = d;
    addr = 7'(raddr);
    #1;
    check("ld_ready", 8'(ld_ready), 8'(m_ready(start)));
    check("data_pre", data, m_mem[raddr]);
    @(posedge clock);
    #1;
    m_step(start, run, valid, d);
    ld_start = 0; run_req = 0; ld_valid = 0;
    check("cpu_run", 8'(cpu_run), 8'(m_phase == PH_RUN));
    check("load_err", 8'(load_err), 8'(m_err));
    check("data_post", data, m_mem[raddr]);
  endtask

  typedef struct {
    bit         st, rq, vl;
    logic [7:0] d;
    bit         e_rdy, e_run, e_err;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit st, bit rq, bit vl, logic [7:0] d, bit er, bit eu, bit ee);
    vec_t v;
    v.st = st; v.rq = rq; v.vl = vl; v.d = d; v.e_rdy = er; v.e_run = eu; v.e_err = ee;
    return v;
  endfunction

  // Apply the table; hand-written expectations are checked as well as the model's
  task automatic run_tbl();
    foreach (tbl[i]) begin
      ld_start = tbl[i].st; run_req = tbl[i].rq; ld_valid = tbl[i].vl; ld_data = tbl[i].d;
      #1;
      check($sformatf("tbl%0d_rdy", i), 8'(ld_ready), 8'(tbl[i].e_rdy));
      #0;
      cycle(tbl[i].st, tbl[i].rq, tbl[i].vl, tbl[i].d, 1);
      check($sformatf("tbl%0d_run", i), 8'(cpu_run), 8'(tbl[i].e_run));
      check($sformatf("tbl%0d_err", i), 8'(load_err), 8'(tbl[i].e_err));
    end
    tbl.delete();
  endtask

  // Well-formed frame with random valid gaps and stray run_req
  task automatic good_frame(input int h);
    int s;
    s = 0;
    cycle(1, 0, 0, 8'h00, $urandom_range(0, 127));
    cycle(0, 0, 1, 8'(h), $urandom_range(0, 127));
    for (int k = 0; k <= h; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      while ($urandom_range(0, 3) == 0) cycle(0, $urandom_range(0, 1), 0, 8'($urandom), k);
      cycle(0, 0, 1, b, k);
      s = (s + int'(b)) % 256;
    end
    cycle(0, 0, 1, 8'(s), $urandom_range(0, 127));
  endtask

  initial begin
    m_reset();
    reset = 0; ld_start = 0; run_req = 0; ld_valid = 0; ld_data = 0; addr = 0;
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 128; k++) check_word(k);
    check("rst_cpu_run", 8'(cpu_run), 8'h00);
    check("rst_ld_ready", 8'(ld_ready), 8'h00);
    check("rst_load_err", 8'(load_err), 8'h00);
    @(posedge clock); #1;
    reset = 1;

    // Good 3-word frame
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h02, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hB3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h01, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hF0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hA4, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h55, 0, 1, 0));
    run_tbl();
    addr = 7'h01; #1; check("addr01", data, 8'h01);
    for (int k = 0; k < 3; k++) check_word(k);

    // Same frame, bad checksum, then run the partial image
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h02, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hB3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h01, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hF0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hA5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 8'h77, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 1));
    run_tbl();
    addr = 7'h00; #1; check("bad_sum_w0", data, 8'hB3);
    addr = 7'h02; #1; check("bad_sum_w2", data, 8'hF0);

    // Oversized header
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h80, 1, 0, 1));
    run_tbl();
    for (int k = 0; k < 4; k++) check_word(k);

    // Full 128-word image, payload k = k
    cycle(1, 0, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'd127, 0);
    for (int k = 0; k < 128; k++) cycle(0, 0, 1, 8'(k), k);
    addr = 7'h40; #1; check("full_w40", data, 8'h40);
    addr = 7'h7F; #1; check("full_w7F", data, 8'h7F);
    cycle(0, 0, 1, 8'hC0, 0);
    check("full_run", 8'(cpu_run), 8'h01);

    // Mid-frame restart: byte with ld_start is dropped, next header accepted
    cycle(1, 0, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h05, 0);
    cycle(0, 0, 1, 8'h9A, 0);
    cycle(0, 0, 1, 8'h9B, 1);
    ld_start = 1; ld_valid = 1; ld_data = 8'hAA; #1;
    check("restart_rdy", 8'(ld_ready), 8'h00);
    cycle(1, 0, 1, 8'hAA, 2);
    cycle(0, 0, 1, 8'h01, 2);
    check("restart_hdr_taken", 8'(ld_ready), 8'h01);
    cycle(0, 0, 1, 8'h11, 0);
    cycle(0, 0, 1, 8'h22, 1);
    cycle(0, 0, 1, 8'h33, 2);
    check("restart_run", 8'(cpu_run), 8'h01);
    addr = 7'h02; #1; check("restart_w2", data, 8'h02);

    // ld_start in RUN drops cpu_run on the next cycle
    cycle(1, 0, 0, 8'h00, 0);
    check("run_drop", 8'(cpu_run), 8'h00);

    // Reset in the middle of a load
    cycle(0, 0, 1, 8'h10, 0);
    cycle(0, 0, 1, 8'hEE, 0);
    #2 reset = 0;
    #1;
    m_reset();
    check("mid_rst_run", 8'(cpu_run), 8'h00);
    check("mid_rst_rdy", 8'(ld_ready), 8'h00);
    for (int k = 0; k < 128; k++) check_word(k);
    @(posedge clock); #1;
    reset = 1;
    cycle(0, 0, 1, 8'h03, 5);
    check("idle_after_rst", 8'(ld_ready), 8'h00);

    // Random well-formed frames interleaved with random traffic
    for (int f = 0; f < 15; f++) begin
      good_frame($urandom_range(0, 20));
      check("rand_frame_run", 8'(cpu_run), 8'h01);
      for (int c = 0; c < 60; c++) begin
        bit st, rq, vl;
        logic [7:0] d;
        int ra;
        st = ($urandom_range(0, 15) == 0);
        rq = ($urandom_range(0, 7) == 0);
        vl = $urandom_range(0, 1);
        d  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
        ra = ($urandom_range(0, 1) == 1) ? (m_next % 128) : $urandom_range(0, 127);
        cycle(st, rq, vl, d, ra);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
